stack_addr_unit: RTL and testbench

Datapath stage directly downstream of the CPU control FSM. It owns the stack pointer (SP) and computes the memory address, write data and write enable from the FSM strobes (FETCH, STORE_MEM, LOAD_SP, SP_INC, SP_DEC, SP_ADDR, DO_JSR). It guards the stack region with sticky overflow/underflow/conflict flags and a high-water-mark depth register. Memory and the PC/AC registers sit beside it; PC and AC are inputs only.

---
 rtl/stack_addr_unit.sv | 127 ++++++++++++
 tb/tb_stack_addr_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_addr_unit.sv
// Stack address unit: owns the stack pointer, steers the memory address and
// write data from the control FSM strobes, and guards the stack region with
// sticky overflow/underflow/conflict flags plus a high-water-mark depth.
module stack_addr_unit #(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 8,
  parameter logic [ADDR_W-1:0] SP_TOP   = 8'hFF,
  parameter logic [ADDR_W-1:0] SP_LIMIT = 8'hC0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FETCH,
  input  logic              STORE_MEM,
  input  logic              LOAD_SP,
  input  logic              SP_INC,
  input  logic              SP_DEC,
  input  logic              SP_ADDR,
  input  logic              DO_JSR,
  input  logic              CLR_FLAGS,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] IRL,
  input  logic [DATA_W-1:0] AC,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] SP,
  output logic [ADDR_W-1:0] DEPTH,
  output logic [ADDR_W-1:0] HWM,
  output logic              SP_OVF,
  output logic              SP_UNF,
  output logic              SP_CONFLICT,
  output logic              FAULT
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] sp_next;
  logic [ADDR_W-1:0] sp_minus1;
  logic [ADDR_W-1:0] hwm_q;
  logic [ADDR_W-1:0] depth_next;
  logic              ovf_q, unf_q, conf_q;
  logic              set_ovf, set_unf, set_conf;
  logic              dec_blk, inc_blk, conflict;

  // Depth below the empty-stack position; an SP loaded above SP_TOP reads as empty.
  function automatic logic [ADDR_W-1:0] depth_of(input logic [ADDR_W-1:0] sp);
    return (sp > SP_TOP) ? '0 : SP_TOP - sp;
  endfunction

  assign sp_minus1 = sp_q - ONE;
  assign dec_blk   = SP_DEC & (sp_q <= SP_LIMIT);
  assign inc_blk   = SP_INC & (sp_q >= SP_TOP);
  assign conflict  = SP_INC & SP_DEC;

  // Address mux: a push addresses the pre-decremented slot in the same cycle,
  // while a pop reads the current top before SP moves at the closing posedge.
  always_comb begin
    if (SP_ADDR && SP_DEC)  MEM_ADDR = sp_minus1;
    else if (SP_ADDR)       MEM_ADDR = sp_q;
    else if (FETCH)         MEM_ADDR = PC;
    else                    MEM_ADDR = IRL;
  end

  assign MEM_WDATA = DO_JSR ? DATA_W'(PC) : AC;
  // A blocked or conflicting push must not corrupt memory below the stack limit.
  assign MEM_WE    = STORE_MEM & ~dec_blk & ~conflict;

  // Next-SP selection and the flag events it raises.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    sp_next  = sp_q;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    set_conf = 1'b0;
    if (LOAD_SP) begin
      sp_next = IRL;
    end else if (conflict) begin
      set_conf = 1'b1;
    end else if (SP_DEC) begin
      if (dec_blk) set_ovf = 1'b1;
      else         sp_next = sp_minus1;
    end else if (SP_INC) begin
      if (inc_blk) set_unf = 1'b1;
      else         sp_next = sp_q + ONE;
    end
  end

  assign depth_next = depth_of(sp_next);

  // Stack pointer, sticky flags and high-water mark; clear beats same-cycle set,
  // and the high-water mark re-accumulates from the cycle after a clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sp_q   <= SP_TOP;
      hwm_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      conf_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, independent of statement order.
      sp_q <= sp_next;
      if (CLR_FLAGS) begin
        hwm_q  <= '0;
        ovf_q  <= 1'b0;
        unf_q  <= 1'b0;
        conf_q <= 1'b0;
      end else begin
        if (depth_next > hwm_q) hwm_q <= depth_next;
        if (set_ovf)  ovf_q  <= 1'b1;
        if (set_unf)  unf_q  <= 1'b1;
        if (set_conf) conf_q <= 1'b1;
      end
    end
  end

  assign SP          = sp_q;
  assign DEPTH       = depth_of(sp_q);
  assign HWM         = hwm_q;
  assign SP_OVF      = ovf_q;
  assign SP_UNF      = unf_q;
  assign SP_CONFLICT = conf_q;
  assign FAULT       = ovf_q | unf_q | conf_q;

endmodule

// File: tb/tb_stack_addr_unit.sv
// Self-checking bench for stack_addr_unit. Strobes change just after negedge,
// outputs are sampled 1 time unit later (well before the next posedge), and
// every expected snapshot goes through a scoreboard queue.
module tb_stack_addr_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       FETCH, STORE_MEM, LOAD_SP, SP_INC, SP_DEC, SP_ADDR, DO_JSR, CLR_FLAGS;
  logic [7:0] PC, IRL, AC;
  logic [7:0] MEM_ADDR, MEM_WDATA, SP, DEPTH, HWM;
  logic       MEM_WE, SP_OVF, SP_UNF, SP_CONFLICT, FAULT;

  typedef struct packed {
    logic fetch, store, load, inc, dec, sa, jsr, clr;
    logic [7:0] pc, irl, ac;
  } stim_t;

  typedef struct packed {
    logic [7:0] addr, wdata;
    logic       we;
    logic [7:0] sp, depth, hwm;
    logic       ovf, unf, conf, fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  stack_addr_unit dut (
    .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .STORE_MEM(STORE_MEM),
    .LOAD_SP(LOAD_SP), .SP_INC(SP_INC), .SP_DEC(SP_DEC), .SP_ADDR(SP_ADDR),
    .DO_JSR(DO_JSR), .CLR_FLAGS(CLR_FLAGS), .PC(PC), .IRL(IRL), .AC(AC),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .SP(SP),
    .DEPTH(DEPTH), .HWM(HWM), .SP_OVF(SP_OVF), .SP_UNF(SP_UNF),
    .SP_CONFLICT(SP_CONFLICT), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t mk_s(input logic fetch, store, load, inc, dec, sa, jsr, clr,
                                 input logic [7:0] pc, irl, ac);
    return '{fetch, store, load, inc, dec, sa, jsr, clr, pc, irl, ac};
  endfunction

  function automatic exp_t mk_e(input logic [7:0] addr, wdata, input logic we,
                                input logic [7:0] sp, depth, hwm,
                                input logic ovf, unf, conf);
    return '{addr, wdata, we, sp, depth, hwm, ovf, unf, conf, ovf | unf | conf};
  endfunction

  function automatic exp_t snap();
    return '{MEM_ADDR, MEM_WDATA, MEM_WE, SP, DEPTH, HWM, SP_OVF, SP_UNF, SP_CONFLICT, FAULT};
  endfunction

  function automatic string fmt(input exp_t v);
    return $sformatf("addr=%h wdata=%h we=%b sp=%h depth=%h hwm=%h ovf/unf/conf/fault=%b%b%b%b",
                     v.addr, v.wdata, v.we, v.sp, v.depth, v.hwm, v.ovf, v.unf, v.conf, v.fault);
  endfunction

  task automatic apply(input stim_t s);
    FETCH = s.fetch; STORE_MEM = s.store; LOAD_SP = s.load; SP_INC = s.inc;
    SP_DEC = s.dec; SP_ADDR = s.sa; DO_JSR = s.jsr; CLR_FLAGS = s.clr;
    PC = s.pc; IRL = s.irl; AC = s.ac;
  endtask

  localparam stim_t IDLE = '0;

  task automatic test_reset();
    exp_t e, o;
    RESET = 1'b1;
    apply(IDLE);
    #2;
    exp_q.push_back(mk_e(8'h00, 8'h00, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 0));
    e = exp_q.pop_front(); o = snap(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_hold: got %s, expected %s", fmt(o), fmt(e)); end
    @(negedge CLK);
    RESET = 1'b0;
    apply(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 8'h12, 8'h00, 8'h00));
    exp_q.push_back(mk_e(8'h12, 8'h00, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); o = snap(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_fetch: got %s, expected %s", fmt(o), fmt(e)); end
    @(negedge CLK);
  endtask

  task automatic test_push();
    stim_t s[2]; exp_t x[2]; exp_t e, o;
    s[0] = mk_s(0, 1, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'hA5);
    x[0] = mk_e(8'hFE, 8'hA5, 1, 8'hFF, 8'h00, 8'h00, 0, 0, 0);
    s[1] = IDLE;
    x[1] = mk_e(8'h00, 8'h00, 0, 8'hFE, 8'h01, 8'h01, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      apply(s[i]); exp_q.push_back(x[i]); #1;
      e = exp_q.pop_front(); o = snap(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL push[%0d]: got %s, expected %s", i, fmt(o), fmt(e)); end
      @(negedge CLK);
    end
  endtask

  task automatic test_jsr_rts();
    stim_t s[3]; exp_t x[3]; exp_t e, o;
    s[0] = mk_s(0, 1, 0, 0, 1, 1, 1, 0, 8'h34, 8'h00, 8'h00);
    x[0] = mk_e(8'hFD, 8'h34, 1, 8'hFE, 8'h01, 8'h01, 0, 0, 0);
    s[1] = mk_s(0, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    x[1] = mk_e(8'hFD, 8'h00, 0, 8'hFD, 8'h02, 8'h02, 0, 0, 0);
    s[2] = IDLE;
    x[2] = mk_e(8'h00, 8'h00, 0, 8'hFE, 8'h01, 8'h02, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]); exp_q.push_back(x[i]); #1;
      e = exp_q.pop_front(); o = snap(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL jsr_rts[%0d]: got %s, expected %s", i, fmt(o), fmt(e)); end
      @(negedge CLK);
    end
  endtask

  task automatic test_overflow_clear();
    stim_t s[5]; exp_t x[5]; exp_t e, o;
    s[0] = mk_s(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'hC0, 8'h00);
    x[0] = mk_e(8'hC0, 8'h00, 0, 8'hFE, 8'h01, 8'h02, 0, 0, 0);
    s[1] = mk_s(0, 1, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'hA5);
    x[1] = mk_e(8'hBF, 8'hA5, 0, 8'hC0, 8'h3F, 8'h3F, 0, 0, 0);
    s[2] = mk_s(0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    x[2] = mk_e(8'h00, 8'h00, 0, 8'hC0, 8'h3F, 8'h3F, 1, 0, 0);
    s[3] = IDLE;
    x[3] = mk_e(8'h00, 8'h00, 0, 8'hC0, 8'h3F, 8'h00, 0, 0, 0);
    s[4] = IDLE;
    x[4] = mk_e(8'h00, 8'h00, 0, 8'hC0, 8'h3F, 8'h3F, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]); exp_q.push_back(x[i]); #1;
      e = exp_q.pop_front(); o = snap(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL overflow_clear[%0d]: got %s, expected %s", i, fmt(o), fmt(e)); end
      @(negedge CLK);
    end
  endtask

  task automatic test_underflow_conflict();
    stim_t s[6]; exp_t x[6]; exp_t e, o;
    s[0] = mk_s(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 8'h00);
    x[0] = mk_e(8'hFF, 8'h00, 0, 8'hC0, 8'h3F, 8'h3F, 0, 0, 0);
    s[1] = mk_s(0, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    x[1] = mk_e(8'hFF, 8'h00, 0, 8'hFF, 8'h00, 8'h3F, 0, 0, 0);
    s[2] = mk_s(0, 1, 0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 8'h5A);
    x[2] = mk_e(8'hFE, 8'h5A, 0, 8'hFF, 8'h00, 8'h3F, 0, 1, 0);
    // Clear coincides with another blocked pop: the clear must win.
    s[3] = mk_s(0, 0, 0, 1, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00);
    x[3] = mk_e(8'hFF, 8'h00, 0, 8'hFF, 8'h00, 8'h3F, 0, 1, 1);
    s[4] = IDLE;
    x[4] = mk_e(8'h00, 8'h00, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 0);
    s[5] = IDLE;
    x[5] = mk_e(8'h00, 8'h00, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]); exp_q.push_back(x[i]); #1;
      e = exp_q.pop_front(); o = snap(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL underflow_conflict[%0d]: got %s, expected %s", i, fmt(o), fmt(e)); end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid_push();
    exp_t e, o;
    apply(mk_s(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'hF0, 8'h00));
    exp_q.push_back(mk_e(8'hF0, 8'h00, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); o = snap(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL mid_reset_load: got %s, expected %s", fmt(o), fmt(e)); end
    @(negedge CLK);
    apply(mk_s(0, 1, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h77));
    exp_q.push_back(mk_e(8'hEF, 8'h77, 1, 8'hF0, 8'h0F, 8'h0F, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); o = snap(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL mid_reset_push: got %s, expected %s", fmt(o), fmt(e)); end
    // Reset lands before the closing posedge; the FSM drops its strobes with it.
    #1;
    RESET = 1'b1;
    apply(IDLE);
    exp_q.push_back(mk_e(8'h00, 8'h00, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); o = snap(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL mid_reset_async: got %s, expected %s", fmt(o), fmt(e)); end
    @(posedge CLK);
    exp_q.push_back(mk_e(8'h00, 8'h00, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); o = snap(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL mid_reset_edge: got %s, expected %s", fmt(o), fmt(e)); end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    exp_q.push_back(mk_e(8'h00, 8'h00, 0, 8'hFF, 8'h00, 8'h00, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); o = snap(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL mid_reset_release: got %s, expected %s", fmt(o), fmt(e)); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_jsr_rts();
    test_overflow_clear();
    test_underflow_conflict();
    test_reset_mid_push();
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
